// File: rtl/sync_ram_pkg.sv
// Shared types, constants and helpers for the sync_ram_bank scratchpad memory.
package sync_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers extend and truncate.
    localparam int MERGE_MAX_DW = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_DW / 8;

    function automatic logic [MERGE_MAX_DW-1:0] byte_merge(
        input logic [MERGE_MAX_DW-1:0] old_w,
        input logic [MERGE_MAX_DW-1:0] new_w,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_ram_if.sv
// Request/response bundle between a bus controller and sync_ram_bank.
interface sync_ram_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                    cs;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    ready;
    logic                    err;

    modport master (
        output cs, we, be, addr, wdata,
        input  rdata, rvalid, ready, err
    );

    modport slave (
        input  cs, we, be, addr, wdata,
        output rdata, rvalid, ready, err
    );
endinterface

// File: rtl/sync_ram_array.sv
// Byte-enable storage array with a registered read port and selectable read-during-write data.
module sync_ram_array
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    rd_en,
    input  logic                    rd_zero,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] old_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Merge lanes and pick the returned word; the read latch only moves on an accepted read.
    always_comb begin
        old_s    = mem_q[addr];
        merged_s = DATA_WIDTH'(byte_merge(MERGE_MAX_DW'(old_s), MERGE_MAX_DW'(wdata),
                                          MERGE_MAX_BE'(be)));
        if ((RDW_MODE == RDW_NEW) && we) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = old_s;
        end
        if (!rd_en) begin
            rdata_d = rdata_q;
        end else if (rd_zero) begin
            rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
            rdata_d = rd_word_s;
        end
    end

    // Storage itself is never reset; the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= merged_s;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_ram_bank.sv
// Single-port scratch RAM bank: zero-fill after reset, range check, optional output stage.
module sync_ram_bank
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_ram_if.slave   bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    acc_s, in_range_s;
    logic                    arr_we_s;
    logic [BE_W-1:0]         arr_be_s;
    logic [ADDR_WIDTH-1:0]   arr_addr_s;
    logic [DATA_WIDTH-1:0]   arr_wdata_s;
    logic [DATA_WIDTH-1:0]   arr_rdata_s;
    logic                    v1_q, v1_d, e1_q, e1_d;
    logic                    v2_q, v2_d, e2_q, e2_d;
    logic [DATA_WIDTH-1:0]   d2_q, d2_d;

    // Clear sequencer: walk every word once, then stay in RUN until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = RUN;
                end else begin
                    state_d = CLEAR;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
        ready_d = (state_d == RUN);
    end

    // Access decode and array port mux (clear sequencer owns the port while clearing).
    always_comb begin
        acc_s      = ready_q & bus.cs;
        in_range_s = (32'(bus.addr) < 32'(DEPTH));
        if (state_q == CLEAR) begin
            arr_we_s    = 1'b1;
            arr_be_s    = {BE_W{1'b1}};
            arr_addr_s  = cnt_q;
            arr_wdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            arr_we_s    = acc_s & bus.we & in_range_s;
            arr_be_s    = bus.be;
            arr_addr_s  = bus.addr;
            arr_wdata_s = bus.wdata;
        end
    end

    // Valid/err pipeline and the optional output data stage.
    always_comb begin
        v1_d = acc_s;
        e1_d = acc_s & ~in_range_s;
        v2_d = v1_q;
        e2_d = e1_q;
        if (v1_q) begin
            d2_d = arr_rdata_s;
        end else begin
            d2_d = d2_q;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
            ready_q <= 1'b0;
            v1_q    <= 1'b0;
            e1_q    <= 1'b0;
            v2_q    <= 1'b0;
            e2_q    <= 1'b0;
            d2_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            v1_q    <= v1_d;
            e1_q    <= e1_d;
            v2_q    <= v2_d;
            e2_q    <= e2_d;
            d2_q    <= d2_d;
        end
    end

    sync_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RDW_MODE   (RDW_MODE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (arr_we_s),
        .rd_en   (acc_s),
        .rd_zero (~in_range_s),
        .be      (arr_be_s),
        .addr    (arr_addr_s),
        .wdata   (arr_wdata_s),
        .rdata   (arr_rdata_s)
    );

    // Output select between the single-stage and two-stage paths.
    always_comb begin
        if (OUT_REG != 0) begin
            bus.rdata  = d2_q;
            bus.rvalid = v2_q;
            bus.err    = e2_q;
        end else begin
            bus.rdata  = arr_rdata_s;
            bus.rvalid = v1_q;
            bus.err    = e1_q;
        end
    end

    assign bus.ready = ready_q;

endmodule

// File: doc/sync_ram_bank.md
# sync_ram_bank

Parametrised single-port synchronous RAM bank, the next generation of the team's basic scratchpad RAM. Adds byte-enable writes, a selectable read-during-write policy, an optional output register stage, a read-valid strobe and a self-clearing initialisation sequencer after reset. Separate read and write data buses replace the bidirectional data bus, so no tristate logic is needed. Sits between a bus slave/controller and local storage wherever the design needs a zero-initialised scratch memory.

## Interface
- ADDR_WIDTH, 4, address bits.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- RDW_MODE, 0, read-during-write policy: 0 = old data, 1 = new (merged) data.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cs  in  1  access request; sampled only while ready=1.
- we  in  1  write qualifier; a cs cycle always reads, and also writes when we=1.
- be  in  DATA_WIDTH/8  byte enables for writes; be[i] covers wdata[8i+7:8i].
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data; holds its last value when rvalid=0.
- rvalid  out  1  one-cycle strobe; rdata is valid this cycle.
- ready  out  1  high once initialisation is complete.
- err  out  1  one-cycle strobe aligned with rvalid; the access had addr ≥ DEPTH.

## Operation
- FSM states: CLEAR, RUN.
  - Reset forces CLEAR and clears the clear-counter.
  - In CLEAR, each cycle writes zero to mem[counter] and increments the counter. ready=0.
  - After mem[DEPTH-1] is written, the FSM moves to RUN and ready=1. RUN is held until the next reset.
- While ready=0, cs/we are ignored: no write, no rvalid, no err.
- Access (RUN, cs=1):
  - Reads mem[addr].
  - If we=1, byte lanes with be[i]=1 are written from wdata. Lanes with be[i]=0 keep their old contents. we=1 with be=0 writes nothing but still returns data.
  - Returned data with we=1: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the merged word (enabled lanes from wdata, the rest old).
  - addr ≥ DEPTH: write dropped, returned data 0, err=1 with rvalid.
- Back-to-back accesses are allowed every cycle, with no bubbles.
- Reset mid-operation restarts CLEAR from address 0. Pipeline contents are discarded and rvalid/err are forced to 0.

## Timing
- Reset values: rdata=0, rvalid=0, err=0, ready=0.
- ready rises in the cycle after the DEPTH-th rising edge with rst_n=1, so CLEAR lasts exactly DEPTH cycles.
- Read latency is the number of edges from the edge sampling cs=1 to the edge after which rvalid=1:
  - 1 for OUT_REG=0.
  - 2 for OUT_REG=1.
- Throughput: one access per cycle. rvalid is a pure delayed copy of the accepted cs.
- Write data is visible to a read issued on the next cycle (write at edge N, read sampled at edge N+1 sees the new value).
- A cs arriving in the cycle ready first rises is accepted.

## Structure
- Shared package sync_ram_pkg holds:
  - state enum {CLEAR, RUN}.
  - RDW_OLD=0, RDW_NEW=1 constants.
  - a function for byte-lane merge (old, new, be).
- One sub-module, sync_ram_array. It is pure storage: byte-enable write port, synchronous read, RDW policy, no reset on the array.
- sync_ram_bank contains the CLEAR/RUN FSM, the clear counter, the address range check, the write mux (clear vs user), the optional output stage and the valid/err pipeline.

## Test plan
- Init: release rst_n, DEPTH=16. Then:
  - ready=0 for 16 cycles, then 1.
  - cs reads of addr 0..15 return 0x00000000 with rvalid one cycle later (OUT_REG=0).
- Byte enables:
  - Write 0xAABBCCDD to addr 3 with be=4'hF.
  - Then write 0x11223344 with be=4'b0101.
  - A read of addr 3 returns 0xAA22CC44.
- RDW policy: addr 5 holds 0x0000FFFF; issue we=1, be=4'hF, wdata=0x12345678.
  - RDW_MODE=0 returns 0x0000FFFF.
  - RDW_MODE=1 returns 0x12345678.
  - A following read returns 0x12345678 in both modes.
- Pipelining: OUT_REG=1 with 4 consecutive reads of addr 0..3 (preloaded 1,2,3,4).
  - rvalid is high for 4 consecutive cycles, starting 2 cycles after the first cs.
  - Data arrives in order 1,2,3,4.
- Range/ignore:
  - DEPTH=12, ADDR_WIDTH=4: a write to addr 13 is dropped; a read of addr 13 gives rdata=0 with rvalid=1 and err=1.
  - cs during CLEAR produces no rvalid.
- Reset mid-operation:
  - Write 0xDEADBEEF to addr 7, then pulse rst_n low for one cycle during an in-flight read.
  - rvalid=0 and ready=0 follow; after 16 cycles a read of addr 7 returns 0.
